// File: rtl/mips_watchdog_timer_param.sv
// Watchdog for the single-cycle MIPS core: prescaled countdown, windowed kick
// checking and a fixed-length registered core-reset pulse on each bite.
module mips_watchdog_timer_param #(
  parameter int unsigned          CNT_WIDTH      = 16,
  parameter int unsigned          PRESCALE_WIDTH = 8,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD = 16'h00FF,
  parameter int unsigned          RST_PULSE_LEN  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_wdt_wait_period_w_en,
  input  logic                 i_wdt_window_w_en,
  input  logic                 i_wdt_prescale_w_en,
  input  logic [CNT_WIDTH-1:0] i_wdt_data,
  input  logic                 i_kick,
  input  logic                 i_flag_clr,
  output logic                 o_cpu_reset,
  output logic                 o_timeout_flag,
  output logic                 o_early_kick_flag,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic [1:0]           o_state
);

  localparam int unsigned       BITE_W    = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [BITE_W-1:0] BITE_LAST = BITE_W'(RST_PULSE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_BITE = 2'b10
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      period_q, period_eff;
  logic [CNT_WIDTH-1:0]      window_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [BITE_W-1:0]         bite_cnt_q, bite_cnt_d;
  logic                      cpu_reset_q, cpu_reset_d;
  logic                      timeout_q, early_q;
  logic                      set_timeout, set_early;
  logic                      tick;

  always_comb begin
    // Reloads see a same-cycle period write; a zero period is stored as 1.
    period_eff = period_q;
    if (i_wdt_wait_period_w_en)
      period_eff = (i_wdt_data == '0) ? CNT_WIDTH'(1) : i_wdt_data;

    state_d     = state_q;
    count_d     = count_q;
    pre_cnt_d   = pre_cnt_q;
    bite_cnt_d  = bite_cnt_q;
    cpu_reset_d = cpu_reset_q;
    set_timeout = 1'b0;
    set_early   = 1'b0;
    tick        = (pre_cnt_q == prescale_q);

    unique case (state_q)
      S_IDLE: begin
        count_d     = period_eff;
        pre_cnt_d   = '0;
        cpu_reset_d = 1'b0;
        if (i_enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!i_enable) begin
          state_d   = S_IDLE;
          count_d   = period_eff;
          pre_cnt_d = '0;
        end else if (i_kick && (count_q > window_q)) begin
          set_early   = 1'b1;
          state_d     = S_BITE;
          cpu_reset_d = 1'b1;
          bite_cnt_d  = '0;
          pre_cnt_d   = '0;
        end else if (i_kick) begin
          count_d   = period_eff;
          pre_cnt_d = '0;
        end else if (tick) begin
          pre_cnt_d = '0;
          if (count_q == CNT_WIDTH'(1)) begin
            count_d     = '0;
            set_timeout = 1'b1;
            state_d     = S_BITE;
            cpu_reset_d = 1'b1;
            bite_cnt_d  = '0;
          end else if (count_q != '0) begin
            count_d = count_q - CNT_WIDTH'(1);
          end
        end else begin
          pre_cnt_d = pre_cnt_q + PRESCALE_WIDTH'(1);
        end
      end
      S_BITE: begin
        if (bite_cnt_q == BITE_LAST) begin
          cpu_reset_d = 1'b0;
          count_d     = period_eff;
          pre_cnt_d   = '0;
          state_d     = i_enable ? S_RUN : S_IDLE;
        end else begin
          bite_cnt_d = bite_cnt_q + BITE_W'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        cpu_reset_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      period_q    <= DEFAULT_PERIOD;
      window_q    <= '1;
      prescale_q  <= '0;
      count_q     <= DEFAULT_PERIOD;
      pre_cnt_q   <= '0;
      bite_cnt_q  <= '0;
      cpu_reset_q <= 1'b0;
      timeout_q   <= 1'b0;
      early_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_eff;
      if (i_wdt_window_w_en)   window_q   <= i_wdt_data;
      if (i_wdt_prescale_w_en) prescale_q <= i_wdt_data[PRESCALE_WIDTH-1:0];
      count_q     <= count_d;
      pre_cnt_q   <= pre_cnt_d;
      bite_cnt_q  <= bite_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      // Set beats a coincident clear.
      timeout_q   <= set_timeout | (timeout_q & ~i_flag_clr);
      early_q     <= set_early   | (early_q   & ~i_flag_clr);
    end
  end

  assign o_cpu_reset       = cpu_reset_q;
  assign o_timeout_flag    = timeout_q;
  assign o_early_kick_flag = early_q;
  assign o_count           = count_q;
  assign o_state           = state_q;

endmodule
